laa_sequencer: RTL

Issue and sequencing controller between the RISC-V core pipeline and the LAA (linear algebra accelerator) register/compute datapath. Accepts one custom-0 LAA instruction at a time over a valid/ready handshake and decodes it into WRITE, READ or MULTIPLY. It drives the LAA bus opcode, address and data for the required number of cycles, stalls the core while an operation is in flight, and returns READ results as a one-cycle core writeback.

---
 rtl/laa_pkg.sv | 41 ++++
 rtl/laa_sequencer_if.sv | 47 ++++
 rtl/laa_ins_decode.sv | 58 +++++
 rtl/laa_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/laa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : laa_pkg
//  Purpose  : Shared types and constants for the LAA issue/sequencing slice:
//             LAA bus opcode encoding, custom-0 instruction decode constants
//             and the sequencer state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package laa_pkg;

    // Major opcode of every LAA instruction (RISC-V custom-0)
    localparam logic [6:0] LAA_CUSTOM_OPC = 7'b0001011;

    // funct field ins[11:7]
    localparam logic [4:0] LAA_F_WRITE = 5'b00010;
    localparam logic [4:0] LAA_F_READ  = 5'b00001;
    localparam logic [4:0] LAA_F_MUL   = 5'b00011;

    // Opcode presented on the LAA bus
    typedef enum logic [1:0] {
        LAA_NONE     = 2'd0,
        LAA_READ     = 2'd1,
        LAA_WRITE    = 2'd2,
        LAA_MULTIPLY = 2'd3
    } laa_opcode_t;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_RWAIT = 3'd3,
        S_MUL   = 3'd4,
        S_MWAIT = 3'd5
    } laa_seq_state_t;

    // Read-latency counter width (READ_LATENCY is limited to 1..7)
    localparam int LAA_LAT_CNT_W = 3;

endpackage : laa_pkg
`default_nettype wire

// File: rtl/laa_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : laa_sequencer_if
//  Purpose  : Bundles the core-side issue/writeback signals and the LAA bus
//             signals of the sequencer.
//  Modports : slave  - the sequencer (consumes instructions, drives LAA bus)
//             master - the environment (core pipeline + LAA datapath)
//  Signals  : ins_valid/ins/rs1_data/ins_ready  instruction handshake
//             core_stall                         pipeline stall
//             laa_opcode/laa_addr/laa_datain     LAA bus request
//             laa_dataout/laa_done               LAA bus response
//             wb_valid/wb_rd/wb_data             core writeback
//             illegal_ins/laa_error              status
//  Revision : 1.0 - initial release
// ============================================================================
interface laa_sequencer_if;

    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] rs1_data;
    logic        ins_ready;
    logic        core_stall;
    logic [1:0]  laa_opcode;
    logic [4:0]  laa_addr;
    logic [31:0] laa_datain;
    logic [31:0] laa_dataout;
    logic        laa_done;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal_ins;
    logic        laa_error;

    modport slave (
        input  ins_valid, ins, rs1_data, laa_dataout, laa_done,
        output ins_ready, core_stall, laa_opcode, laa_addr, laa_datain,
               wb_valid, wb_rd, wb_data, illegal_ins, laa_error
    );

    modport master (
        output ins_valid, ins, rs1_data, laa_dataout, laa_done,
        input  ins_ready, core_stall, laa_opcode, laa_addr, laa_datain,
               wb_valid, wb_rd, wb_data, illegal_ins, laa_error
    );

endinterface : laa_sequencer_if
`default_nettype wire

// File: rtl/laa_ins_decode.sv
`default_nettype none
// ============================================================================
//  Module   : laa_ins_decode
//  Purpose  : Combinational decode of a custom-0 LAA instruction word.
//  Ports    : ins       in  32  instruction word
//             kind      out  2  LAA operation (LAA_NONE when illegal)
//             laa_reg   out  5  LAA register (WRITE: ins[26:22], READ: ins[31:27])
//             core_reg  out  5  core register (WRITE: rs1 ins[31:27], READ: rd ins[26:22])
//             illegal   out  1  word is not a decodable LAA instruction
//  Revision : 1.0 - initial release
// ============================================================================
module laa_ins_decode
    import laa_pkg::*;
(
    input  logic [31:0] ins,
    output laa_opcode_t kind,
    output logic [4:0]  laa_reg,
    output logic [4:0]  core_reg,
    output logic        illegal
);

    // ins[21:12] carries no information for any LAA instruction
    logic w_unused_fill;
    assign w_unused_fill = ^ins[21:12];

    always_comb begin
        kind     = LAA_NONE;
        laa_reg  = 5'd0;
        core_reg = 5'd0;
        illegal  = 1'b1;
        if (ins[6:0] == LAA_CUSTOM_OPC) begin
            case (ins[11:7])
                LAA_F_WRITE: begin
                    kind     = LAA_WRITE;
                    laa_reg  = ins[26:22];
                    core_reg = ins[31:27];
                    illegal  = 1'b0;
                end
                LAA_F_READ: begin
                    // Register roles swap for READ: source is the LAA register
                    kind     = LAA_READ;
                    laa_reg  = ins[31:27];
                    core_reg = ins[26:22];
                    illegal  = 1'b0;
                end
                LAA_F_MUL: begin
                    kind     = LAA_MULTIPLY;
                    illegal  = 1'b0;
                end
                default: begin
                    illegal  = 1'b1;
                end
            endcase
        end
    end

endmodule : laa_ins_decode
`default_nettype wire

// File: rtl/laa_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : laa_sequencer
//  Purpose  : Issues one LAA instruction at a time from the core to the LAA
//             datapath, drives the LAA bus for the required cycles, stalls the
//             core while busy and returns READ results as a one-cycle
//             writeback.
//  Ports    : clk   core clock
//             rst   synchronous active-high reset
//             bus   laa_sequencer_if.slave (handshake, LAA bus, writeback,
//                   status)
//  Params   : READ_LATENCY  cycles from READ opcode to valid laa_dataout (1..7)
//             MUL_TIMEOUT   S_MWAIT cycle limit (only with LAA_SEQ_TIMEOUT_EN)
//  Macro    : LAA_SEQ_TIMEOUT_EN - enables the multiply timeout and the sticky
//             laa_error flag; without it S_MWAIT waits forever and laa_error
//             is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module laa_sequencer
    import laa_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int MUL_TIMEOUT  = 1024
)(
    input  wire logic     clk,
    input  wire logic     rst,
    laa_sequencer_if.slave bus
);

    localparam logic [LAA_LAT_CNT_W-1:0] c_lat_last = LAA_LAT_CNT_W'(READ_LATENCY - 1);

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    laa_opcode_t w_kind;
    logic [4:0]  w_laa_reg;
    logic [4:0]  w_core_reg;
    logic        w_illegal;

    laa_ins_decode u_decode (
        .ins      (bus.ins),
        .kind     (w_kind),
        .laa_reg  (w_laa_reg),
        .core_reg (w_core_reg),
        .illegal  (w_illegal)
    );

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    laa_seq_state_t            r_state,     w_state_nxt;
    laa_opcode_t               r_opcode,    w_opcode_nxt;
    logic [4:0]                r_addr,      w_addr_nxt;
    logic [31:0]               r_datain,    w_datain_nxt;
    logic [4:0]                r_rd,        w_rd_nxt;
    logic                      r_wb_valid,  w_wb_valid_nxt;
    logic [4:0]                r_wb_rd,     w_wb_rd_nxt;
    logic [31:0]               r_wb_data,   w_wb_data_nxt;
    logic                      r_illegal,   w_illegal_nxt;
    logic [LAA_LAT_CNT_W-1:0]  r_lat_cnt,   w_lat_cnt_nxt;

`ifdef LAA_SEQ_TIMEOUT_EN
    localparam int c_mul_cnt_w = $clog2(MUL_TIMEOUT + 1);
    localparam logic [c_mul_cnt_w-1:0] c_mul_last = c_mul_cnt_w'(MUL_TIMEOUT - 1);

    logic [c_mul_cnt_w-1:0]    r_mul_cnt,   w_mul_cnt_nxt;
    logic                      r_error,     w_error_nxt;
`else
    localparam int unused_mul_timeout = MUL_TIMEOUT;
`endif

    logic w_accept;
    assign w_accept = bus.ins_valid && (r_state == S_IDLE);

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_datain_nxt   = r_datain;
        w_rd_nxt       = r_rd;
        w_wb_valid_nxt = 1'b0;
        w_wb_rd_nxt    = r_wb_rd;
        w_wb_data_nxt  = r_wb_data;
        w_illegal_nxt  = 1'b0;
        w_lat_cnt_nxt  = r_lat_cnt;
`ifdef LAA_SEQ_TIMEOUT_EN
        w_mul_cnt_nxt  = r_mul_cnt;
        w_error_nxt    = r_error;
`endif

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_illegal) begin
                        // Consumed but not executed
                        w_illegal_nxt = 1'b1;
                    end else begin
                        case (w_kind)
                            LAA_WRITE: begin
                                w_addr_nxt   = w_laa_reg;
                                w_datain_nxt = bus.rs1_data;
                                w_state_nxt  = S_WRITE;
                            end
                            LAA_READ: begin
                                w_addr_nxt   = w_laa_reg;
                                w_rd_nxt     = w_core_reg;
                                w_state_nxt  = S_READ;
                            end
                            LAA_MULTIPLY: begin
                                w_state_nxt  = S_MUL;
                            end
                            default: begin
                                w_state_nxt  = S_IDLE;
                            end
                        endcase
                    end
                end
            end

            S_WRITE: begin
                w_state_nxt = S_IDLE;
            end

            S_READ: begin
                w_lat_cnt_nxt = '0;
                w_state_nxt   = S_RWAIT;
            end

            S_RWAIT: begin
                if (r_lat_cnt == c_lat_last) begin
                    // laa_dataout is valid this cycle; writeback appears in
                    // the first S_IDLE cycle. x0 is never written.
                    w_state_nxt = S_IDLE;
                    if (r_rd != 5'd0) begin
                        w_wb_valid_nxt = 1'b1;
                        w_wb_rd_nxt    = r_rd;
                        w_wb_data_nxt  = bus.laa_dataout;
                    end
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt + 1'b1;
                end
            end

            S_MUL: begin
`ifdef LAA_SEQ_TIMEOUT_EN
                w_mul_cnt_nxt = '0;
`endif
                w_state_nxt = S_MWAIT;
            end

            S_MWAIT: begin
                if (bus.laa_done) begin
                    w_state_nxt = S_IDLE;
                end
`ifdef LAA_SEQ_TIMEOUT_EN
                else if (r_mul_cnt == c_mul_last) begin
                    w_state_nxt = S_IDLE;
                    w_error_nxt = 1'b1;
                end else begin
                    w_mul_cnt_nxt = r_mul_cnt + 1'b1;
                end
`endif
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // The bus opcode is registered from the upcoming state so it lines
        // up exactly with the S_WRITE / S_READ / S_MUL cycle.
        case (w_state_nxt)
            S_WRITE: w_opcode_nxt = LAA_WRITE;
            S_READ:  w_opcode_nxt = LAA_READ;
            S_MUL:   w_opcode_nxt = LAA_MULTIPLY;
            default: w_opcode_nxt = LAA_NONE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_opcode   <= LAA_NONE;
            r_addr     <= 5'd0;
            r_datain   <= 32'd0;
            r_rd       <= 5'd0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= 32'd0;
            r_illegal  <= 1'b0;
            r_lat_cnt  <= '0;
`ifdef LAA_SEQ_TIMEOUT_EN
            r_mul_cnt  <= '0;
            r_error    <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_opcode   <= w_opcode_nxt;
            r_addr     <= w_addr_nxt;
            r_datain   <= w_datain_nxt;
            r_rd       <= w_rd_nxt;
            r_wb_valid <= w_wb_valid_nxt;
            r_wb_rd    <= w_wb_rd_nxt;
            r_wb_data  <= w_wb_data_nxt;
            r_illegal  <= w_illegal_nxt;
            r_lat_cnt  <= w_lat_cnt_nxt;
`ifdef LAA_SEQ_TIMEOUT_EN
            r_mul_cnt  <= w_mul_cnt_nxt;
            r_error    <= w_error_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ins_ready   = (r_state == S_IDLE);
    assign bus.core_stall  = (r_state != S_IDLE);
    assign bus.laa_opcode  = r_opcode;
    assign bus.laa_addr    = r_addr;
    assign bus.laa_datain  = r_datain;
    assign bus.wb_valid    = r_wb_valid;
    assign bus.wb_rd       = r_wb_rd;
    assign bus.wb_data     = r_wb_data;
    assign bus.illegal_ins = r_illegal;
`ifdef LAA_SEQ_TIMEOUT_EN
    assign bus.laa_error   = r_error;
`else
    assign bus.laa_error   = 1'b0;
`endif

endmodule : laa_sequencer
`default_nettype wire
